// File: rtl/mem_arbiter_pkg.sv
// Shared types and encodings for the RAM arbiter: FSM states, port indices, RW codes.
package mem_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      STROBE  = 3'd2,
      DONE    = 3'd3,
      RECOVER = 3'd4
   } state_e;

   localparam logic PORT_IF  = 1'b0;
   localparam logic PORT_D   = 1'b1;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_arbiter_moc_catch.sv
// Catches the short asynchronous MOC pulse in a flag and brings it into clk via two flops.
// clear_i (reset or moc_clr) empties the flag and the synchronizer at once.
module moc_catch (
   input  logic clk_i,
   input  logic rst_i,
   input  logic moc_clr_i,
   input  logic mem_moc_i,
   output logic moc_seen_o
);

   logic clr;
   logic flag_q;
   logic sync1_q;
   logic sync2_q;

   assign clr = rst_i | moc_clr_i;

   always_ff @(posedge mem_moc_i or posedge clr) begin
      if (clr) flag_q <= 1'b0;
      else     flag_q <= 1'b1;
   end

   always_ff @(posedge clk_i or posedge clr) begin
      if (clr) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= flag_q;
         sync2_q <= sync1_q;
      end
   end

   assign moc_seen_o = sync2_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between fetch and data ports for the single-port RAM, sequencing
// Enable/MOV/RW strobes and finishing each access on MOC, on timeout, or on a bad address.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int MEM_WORDS = 128,
   parameter int TIMEOUT   = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic              if_err,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_rw,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic              d_err,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_enable,
   output logic              mem_mov,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   input  logic              mem_moc,
   output logic              busy
);

   localparam int              CNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W + 1)'(MEM_WORDS);

   state_e              state_q, state_d;
   logic                grant_q, grant_d;
   logic                last_q, last_d;
   logic                rw_q, rw_d;
   logic                err_q, err_d;
   logic                oor_q, oor_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                moc_clr_q;
   logic                moc_seen;

   logic                req_port;
   logic [ADDR_W-1:0]   req_addr;
   logic                req_rw;
   logic [DATA_W-1:0]   req_wdata;
   logic                req_oor;

   moc_catch u_moc_catch (
      .clk_i      (clk),
      .rst_i      (reset),
      .moc_clr_i  (moc_clr_q),
      .mem_moc_i  (mem_moc),
      .moc_seen_o (moc_seen)
   );

   // On contention the port not served last wins.
   always_comb begin
      req_port = d_req ? PORT_D : PORT_IF;
      if (if_req && d_req) req_port = (last_q == PORT_D) ? PORT_IF : PORT_D;
      req_addr  = (req_port == PORT_D) ? d_addr : if_addr;
      req_rw    = (req_port == PORT_D) ? d_rw : RW_READ;
      req_wdata = (req_port == PORT_D && d_rw == RW_WRITE) ? d_wdata : '0;
      req_oor   = {1'b0, req_addr} >= MEM_LIMIT;
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      rw_d       = rw_q;
      err_d      = err_q;
      oor_d      = oor_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      cnt_d      = '0;
      unique case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               grant_d = req_port;
               last_d  = req_port;
               addr_d  = req_addr;
               rw_d    = req_rw;
               wdata_d = req_wdata;
               oor_d   = req_oor;
               err_d   = req_oor;
               state_d = req_oor ? DONE : SETUP;
            end
         end
         SETUP: state_d = STROBE;
         STROBE: begin
            if (moc_seen) begin
               state_d = DONE;
               err_d   = 1'b0;
               if (rw_q == RW_READ) begin
                  if (grant_q == PORT_IF) if_rdata_d = mem_dout;
                  else                    d_rdata_d  = mem_dout;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = DONE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    state_d = RECOVER;
         RECOVER: if (!moc_seen) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // moc_clr is registered so the asynchronous clear of the catch flag never glitches;
   // it stays high outside STROBE/DONE so stray MOC pulses cannot arm the next access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         grant_q    <= PORT_IF;
         last_q     <= PORT_D;
         rw_q       <= 1'b0;
         err_q      <= 1'b0;
         oor_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         cnt_q      <= '0;
         moc_clr_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         rw_q       <= rw_d;
         err_q      <= err_d;
         oor_q      <= oor_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         cnt_q      <= cnt_d;
         moc_clr_q  <= (state_d != STROBE) && (state_d != DONE);
      end
   end

   logic active;
   assign active     = (state_q == SETUP) || (state_q == STROBE) || (state_q == DONE);
   assign busy       = (state_q != IDLE);
   assign mem_enable = active && !oor_q;
   assign mem_mov    = (state_q == STROBE);
   assign mem_rw     = active ? rw_q : 1'b0;
   assign mem_addr   = active ? addr_q : '0;
   assign mem_din    = active ? wdata_q : '0;

   assign if_ack   = (state_q == DONE) && (grant_q == PORT_IF);
   assign d_ack    = (state_q == DONE) && (grant_q == PORT_D);
   assign if_err   = if_ack && err_q;
   assign d_err    = d_ack && err_q;
   assign if_rdata = if_rdata_q;
   assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: RAM model with MOC pulses, scoreboard of expected acks.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int ADDR_W = 8, DATA_W = 32, MEM_WORDS = 128, TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              reset;
   logic              if_req = 1'b0, d_req = 1'b0, d_rw = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0, d_addr = '0;
   logic [DATA_W-1:0] d_wdata = '0, mem_dout = '0;
   logic              mem_moc = 1'b0;
   logic              if_ack, if_err, d_ack, d_err;
   logic              mem_enable, mem_mov, mem_rw, busy;
   logic [DATA_W-1:0] if_rdata, d_rdata, mem_din;
   logic [ADDR_W-1:0] mem_addr;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
      .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
      .mem_enable(mem_enable), .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_moc(mem_moc), .busy(busy)
   );

   // RAM model: performs the access and pulses MOC (3 ns, shorter than a clock) after MOV.
   logic [DATA_W-1:0] ram [0:MEM_WORDS-1];
   bit                moc_en = 1'b1;
   always @(posedge mem_mov) begin
      if (moc_en && mem_enable) begin
         #2;
         if (mem_rw == RW_READ) mem_dout = ram[mem_addr[6:0]];
         else                   ram[mem_addr[6:0]] = mem_din;
         mem_moc = 1'b1;
         #3 mem_moc = 1'b0;
      end
   end

   typedef struct packed {
      logic              port;
      logic              err;
      logic              rd;
      logic [DATA_W-1:0] rdata;
   } exp_t;

   exp_t              exp_q[$];
   exp_t              cur;
   logic [DATA_W-1:0] shadow [0:255];
   logic [DATA_W-1:0] exp_if_rdata = '0, exp_d_rdata = '0;
   int                checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic port, input logic rw, input logic [7:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic err);
      exp_t e;
      e.port  = port;
      e.err   = err;
      e.rd    = (port == PORT_IF) || (rw == RW_READ);
      e.rdata = (e.rd && !err) ? shadow[addr] : '0;
      if (!e.rd && !err) shadow[addr] = wdata;
      exp_q.push_back(e);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 20) begin @(negedge clk); n++; end
      chk("wait_idle", busy, 0);
   endtask

   // One access on one port; returns cycles to ack and cycles with MOV high.
   task automatic access(input logic port, input logic rw, input logic [7:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic exp_err,
                         output int lat, output int movc);
      bit got = 1'b0;
      push_exp(port, rw, addr, wdata, exp_err);
      @(negedge clk);
      wait_idle();
      if (port == PORT_IF) begin
         if_req = 1'b1; if_addr = addr;
      end else begin
         d_req = 1'b1; d_rw = rw; d_addr = addr; d_wdata = wdata;
      end
      lat = 0; movc = 0;
      while (!got && lat < 100) begin
         @(negedge clk);
         lat++;
         if (mem_mov) begin
            movc++;
            chk("strobe_addr", mem_addr, addr);
            chk("strobe_rw", mem_rw, (port == PORT_IF) ? RW_READ : rw);
         end
         got = (port == PORT_IF) ? if_ack : d_ack;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL access_ack: no ack after %0d cycles, required one", lat);
      end
      if_req = 1'b0; d_req = 1'b0;
   endtask

   // Compare process: acks against scoreboard, rdata holding, idle bus quiet.
   always @(negedge clk) begin
      if (reset) begin
         chk("reset_ctrl", {busy, mem_enable, mem_mov, mem_rw, if_ack, d_ack, if_err, d_err}, 0);
         chk("reset_addr", 32'(mem_addr), 0);
         chk("reset_din", mem_din, 0);
         chk("reset_if_rdata", if_rdata, 0);
         chk("reset_d_rdata", d_rdata, 0);
      end else begin
         if (if_ack || d_ack) begin
            chk("single_ack", if_ack && d_ack, 0);
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_ack: if_ack=%b d_ack=%b, required none", if_ack, d_ack);
            end else begin
               cur = exp_q.pop_front();
               chk("ack_port", d_ack, cur.port);
               chk("ack_err", d_ack ? d_err : if_err, cur.err);
               if (cur.rd && !cur.err) begin
                  if (cur.port == PORT_IF) exp_if_rdata = cur.rdata;
                  else                     exp_d_rdata  = cur.rdata;
               end
            end
         end else begin
            chk("err_without_ack", if_err || d_err, 0);
         end
         chk("if_rdata", if_rdata, exp_if_rdata);
         chk("d_rdata", d_rdata, exp_d_rdata);
         if (!busy) begin
            chk("idle_bus", {mem_enable, mem_mov, mem_rw, mem_addr, if_ack, d_ack}, 0);
            chk("idle_din", mem_din, 0);
         end
         if (mem_mov) chk("mov_enable", mem_enable, 1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat, movc, ifc, dc;
      logic [5:0] ord;
      for (int i = 0; i < MEM_WORDS; i++) ram[i] = '0;
      for (int i = 0; i < 256; i++) shadow[i] = '0;
      ram[5] = 32'hDEADBEEF;
      shadow[5] = 32'hDEADBEEF;
      reset = 1'b0;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Fetch read
      access(PORT_IF, RW_READ, 8'd5, '0, 1'b0, lat, movc);
      chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
      chk("fetch_latency_5_6", (lat >= 5 && lat <= 6), 1);
      chk("fetch_mov_seen", movc > 0, 1);
      chk("fetch_mov_low_at_ack", mem_mov, 0);

      // Data write then read at the top valid address
      access(PORT_D, RW_WRITE, 8'h7F, 32'h12345678, 1'b0, lat, movc);
      access(PORT_D, RW_READ, 8'h7F, '0, 1'b0, lat, movc);
      chk("data_readback", d_rdata, 32'h12345678);

      // Contention: last grant is data, so fetch, data, fetch
      push_exp(PORT_IF, RW_READ, 8'd5, '0, 1'b0);
      push_exp(PORT_D, RW_READ, 8'h7F, '0, 1'b0);
      push_exp(PORT_IF, RW_READ, 8'd5, '0, 1'b0);
      @(negedge clk);
      wait_idle();
      if_req = 1'b1; if_addr = 8'd5;
      d_req = 1'b1; d_rw = RW_READ; d_addr = 8'h7F;
      ifc = 0; dc = 0; ord = '0;
      for (int c = 0; c < 200 && !(ifc == 2 && dc == 1); c++) begin
         @(negedge clk);
         if (if_ack) begin ord = {ord[3:0], 2'b01}; ifc++; if (ifc == 2) if_req = 1'b0; end
         if (d_ack)  begin ord = {ord[3:0], 2'b10}; dc++; d_req = 1'b0; end
      end
      if_req = 1'b0; d_req = 1'b0;
      chk("contention_order", ord, 6'b01_10_01);

      // Out-of-range data read: immediate error, no strobe, rdata unchanged
      access(PORT_D, RW_READ, 8'h80, '0, 1'b1, lat, movc);
      chk("oor_latency", lat <= 2, 1);
      chk("oor_no_mov", movc, 0);
      chk("oor_rdata_kept", d_rdata, 32'h12345678);

      // Timeout: RAM never answers
      moc_en = 1'b0;
      access(PORT_D, RW_READ, 8'h10, '0, 1'b1, lat, movc);
      chk("timeout_strobe_cycles", movc, TIMEOUT);
      chk("timeout_latency", lat, TIMEOUT + 2);
      chk("timeout_rdata_kept", d_rdata, 32'h12345678);
      @(negedge clk);
      wait_idle();
      moc_en = 1'b1;

      // Reset in the middle of STROBE
      moc_en = 1'b0;
      d_req = 1'b1; d_rw = RW_WRITE; d_addr = 8'd3; d_wdata = 32'hAAAA5555;
      repeat (4) @(negedge clk);
      chk("pre_reset_in_strobe", mem_mov, 1);
      @(posedge clk);
      #2 reset = 1'b1;
      exp_if_rdata = '0;
      exp_d_rdata = '0;
      #1;
      chk("async_reset_ctrl", {busy, mem_enable, mem_mov, mem_rw, d_ack, d_err}, 0);
      chk("async_reset_addr", 32'(mem_addr), 0);
      chk("async_reset_rdata", d_rdata, 0);
      d_req = 1'b0;
      moc_en = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("no_pending_after_reset", exp_q.size(), 0);

      // New request after release completes normally
      access(PORT_IF, RW_READ, 8'd5, '0, 1'b0, lat, movc);
      chk("post_reset_fetch", if_rdata, 32'hDEADBEEF);
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
